// File: rtl/matmul_session_ctrl.sv
// matmul_session_ctrl
//   Sequencer for one UART matrix-multiply session on the baud-domain clock.
//   The session runs in this order:
//     1. Wait for the sync byte.
//     2. Accept the matrix size N (1..MAX_SIZE).
//     3. Write N*N elements of A, then N*N elements of B, row-major.
//     4. Enable the multiplier and wait for mult_done.
//     5. Stream the N*N result bytes to uart_tx, using a
//        start / wait-busy / wait-idle handshake per byte.
//
// Ports
//   clk, rst           clock, asynchronous active-low reset
//   rx_data, rx_valid  received byte + one-cycle strobe
//   tx_busy            uart_tx busy flag
//   mult_done          multiplier completion flag
//   res_byte           result byte for res_idx, selected outside
//   matrix_size        latched N
//   wr_addr, wr_data   memory write index (i*N+j) and data
//   wr_en_a, wr_en_b   one-cycle write strobes for the A / B memories
//   mult_enable        high while computing
//   res_idx            result element currently being sent
//   tx_data, tx_start  byte and one-cycle start strobe to uart_tx
//   state              current FSM state encoding
//   size_err           one-cycle pulse on a rejected size byte
module matmul_session_ctrl #(
  parameter int         MAX_SIZE  = 10,
  parameter int         ADDR_W    = 7,
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  input  logic              tx_busy,
  input  logic              mult_done,
  input  logic [7:0]        res_byte,
  output logic [3:0]        matrix_size,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              wr_en_a,
  output logic              wr_en_b,
  output logic              mult_enable,
  output logic [ADDR_W-1:0] res_idx,
  output logic [7:0]        tx_data,
  output logic              tx_start,
  output logic [2:0]        state,
  output logic              size_err
);

  typedef enum logic [2:0] {
    IDLE           = 3'd0,
    RECV_SIZE      = 3'd1,
    RECV_A         = 3'd2,
    RECV_B         = 3'd3,
    COMPUTE        = 3'd4,
    SEND_START     = 3'd5,
    SEND_WAIT_BUSY = 3'd6,
    SEND_WAIT_IDLE = 3'd7
  } state_t;

  localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

  state_t            cur, nxt;
  logic [ADDR_W-1:0] cnt, total;

  logic [ADDR_W-1:0] cnt_n, total_n, res_idx_n, wr_addr_n, n_ext;
  logic [3:0]        size_n;
  logic [7:0]        wr_data_n, tx_data_n;
  logic              wr_a_n, wr_b_n, tx_start_n, size_err_n;
  logic              size_ok, last_elem, last_res;

  // Full-byte range check: 0x13 must be rejected even though its low nibble is 3.
  assign size_ok   = (rx_data != 8'd0) && (rx_data <= 8'(MAX_SIZE));
  assign n_ext     = ADDR_W'(rx_data[3:0]);
  // total is never 0 outside IDLE/RECV_SIZE, so total-1 cannot underflow where used.
  assign last_elem = (cnt == total - ONE);
  assign last_res  = (res_idx == total - ONE);

  assign state       = cur;
  assign mult_enable = (cur == COMPUTE);

  always_comb begin
    nxt        = cur;
    cnt_n      = cnt;
    total_n    = total;
    res_idx_n  = res_idx;
    size_n     = matrix_size;
    wr_addr_n  = wr_addr;
    wr_data_n  = wr_data;
    tx_data_n  = tx_data;
    wr_a_n     = 1'b0;
    wr_b_n     = 1'b0;
    tx_start_n = 1'b0;
    size_err_n = 1'b0;
    case (cur)
      IDLE: begin
        if (rx_valid && rx_data == SYNC_BYTE) nxt = RECV_SIZE;
      end
      RECV_SIZE: begin
        if (rx_valid) begin
          if (size_ok) begin
            size_n  = rx_data[3:0];
            total_n = n_ext * n_ext;
            cnt_n   = '0;
            nxt     = RECV_A;
          end else begin
            size_err_n = 1'b1;
          end
        end
      end
      RECV_A, RECV_B: begin
        if (rx_valid) begin
          // Strobe, address and data are registered together, so the write
          // lands one cycle after rx_valid.
          wr_a_n    = (cur == RECV_A);
          wr_b_n    = (cur == RECV_B);
          wr_addr_n = cnt;
          wr_data_n = rx_data;
          if (last_elem) begin
            cnt_n = '0;
            nxt   = (cur == RECV_A) ? RECV_B : COMPUTE;
          end else begin
            cnt_n = cnt + ONE;
          end
        end
      end
      COMPUTE: begin
        if (mult_done) begin
          res_idx_n = '0;
          nxt       = SEND_START;
        end
      end
      SEND_START: begin
        // tx_start and tx_data are registered on the same edge, so uart_tx
        // sees them together.
        if (!tx_busy) begin
          tx_start_n = 1'b1;
          tx_data_n  = res_byte;
          nxt        = SEND_WAIT_BUSY;
        end
      end
      SEND_WAIT_BUSY: begin
        // Waiting for acceptance keeps a late busy rise from looking like
        // "already idle", which would repeat a byte.
        if (tx_busy) nxt = SEND_WAIT_IDLE;
      end
      SEND_WAIT_IDLE: begin
        if (!tx_busy) begin
          if (last_res) begin
            res_idx_n = '0;
            nxt       = IDLE;
          end else begin
            res_idx_n = res_idx + ONE;
            nxt       = SEND_START;
          end
        end
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cur <= IDLE;
    else      cur <= nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt         <= '0;
      total       <= '0;
      res_idx     <= '0;
      matrix_size <= '0;
      wr_addr     <= '0;
      wr_data     <= '0;
      tx_data     <= '0;
      wr_en_a     <= 1'b0;
      wr_en_b     <= 1'b0;
      tx_start    <= 1'b0;
      size_err    <= 1'b0;
    end else begin
      cnt         <= cnt_n;
      total       <= total_n;
      res_idx     <= res_idx_n;
      matrix_size <= size_n;
      wr_addr     <= wr_addr_n;
      wr_data     <= wr_data_n;
      tx_data     <= tx_data_n;
      wr_en_a     <= wr_a_n;
      wr_en_b     <= wr_b_n;
      tx_start    <= tx_start_n;
      size_err    <= size_err_n;
    end
  end

endmodule

// File: tb/tb_matmul_session_ctrl.sv
// Bench for matmul_session_ctrl: a table of size-phase vectors plus complete
// sessions. The sessions use random matrices and a small uart_tx busy model.
// The reference is the matrix product itself (mod 256) and the rule that
// every element is written once in row-major order and every result is sent
// once, in index order.
module tb_matmul_session_ctrl;
  localparam int         MAX_SIZE = 10;
  localparam int         ADDR_W   = 7;
  localparam logic [7:0] SYNC     = 8'hA5;

  logic              clk = 1'b0, rst = 1'b0;
  logic [7:0]        rx_data = '0, res_byte = '0;
  logic              rx_valid = 1'b0, tx_busy = 1'b0, mult_done = 1'b0;
  logic [3:0]        matrix_size;
  logic [ADDR_W-1:0] wr_addr, res_idx;
  logic [7:0]        wr_data, tx_data;
  logic              wr_en_a, wr_en_b, mult_enable, tx_start, size_err;
  logic [2:0]        state;

  always #5 clk = ~clk;

  matmul_session_ctrl #(.MAX_SIZE(MAX_SIZE), .ADDR_W(ADDR_W), .SYNC_BYTE(SYNC)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .tx_busy(tx_busy),
    .mult_done(mult_done), .res_byte(res_byte), .matrix_size(matrix_size),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_en_a(wr_en_a), .wr_en_b(wr_en_b),
    .mult_enable(mult_enable), .res_idx(res_idx), .tx_data(tx_data),
    .tx_start(tx_start), .state(state), .size_err(size_err));

  int checks = 0, errors = 0;
  int cmod[100];
  int d_cnt = 0, l_cnt = 0, busy_dly = 1, busy_len = 20;

  typedef struct {
    bit         v;
    logic [7:0] b;
    int         st;
    int         serr;
    int         msz;
  } vec_t;
  vec_t tbl[9];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_a"}, int'({matrix_size, wr_addr, wr_data, wr_en_a, wr_en_b, mult_enable}), 0);
    chk({nm, "_b"}, int'({res_idx, tx_data, tx_start, state, size_err}), 0);
  endtask

  // One clock: sample at edge+1, run the uart_tx busy model, present res_byte.
  task automatic step();
    bit b0;
    b0 = tx_busy;
    @(posedge clk); #1;
    if (wr_en_a || wr_en_b) chk("wr_exclusive", int'(wr_en_a & wr_en_b), 0);
    if (tx_start) begin
      chk("start_while_busy", int'(b0), 0);
      chk("start_with_enable", int'(mult_enable), 0);
    end
    if (tx_start) begin
      if (busy_dly == 0) begin tx_busy = 1'b1; l_cnt = busy_len; end
      else d_cnt = busy_dly;
    end else if (d_cnt > 0) begin
      d_cnt--;
      if (d_cnt == 0) begin tx_busy = 1'b1; l_cnt = busy_len; end
    end else if (l_cnt > 0) begin
      l_cnt--;
      if (l_cnt == 0) tx_busy = 1'b0;
    end
    res_byte = (int'(res_idx) < 100) ? 8'(cmod[int'(res_idx)]) : 8'h00;
  endtask

  task automatic send(input logic [7:0] b);
    rx_data = b; rx_valid = 1'b1; step(); rx_valid = 1'b0;
  endtask

  // Everything after the size byte: element writes, compute, result stream.
  task automatic body(input int n, input bit fixed, input bit gaps, input int pre_busy,
                      input int abort_at);
    int a[100], b[100];
    int tot, got, k, s, d, exp;
    tot = n * n;
    for (int i = 0; i < tot; i++) begin
      a[i] = fixed ? i + 1 : int'($urandom_range(0, 255));
      b[i] = fixed ? i + 5 : int'($urandom_range(0, 255));
    end
    for (int i = 0; i < n; i++)
      for (int j = 0; j < n; j++) begin
        s = 0;
        for (int m = 0; m < n; m++) s += a[i*n+m] * b[m*n+j];
        cmod[i*n+j] = s % 256;
      end
    for (int m = 0; m < 2; m++)
      for (int i = 0; i < tot; i++) begin
        if (gaps) repeat ($urandom_range(0, 2)) step();
        d = (m == 0) ? a[i] : b[i];
        send(8'(d));
        exp = ((m == 0) ? (1 << 16) : (1 << 15)) | (i << 8) | d;
        chk("write", int'({wr_en_a, wr_en_b, wr_addr, wr_data}), exp);
      end
    chk("compute_state", int'({state, mult_enable}), (4 << 1) | 1);
    send(SYNC);
    chk("compute_ignore_rx", int'({wr_en_a, wr_en_b, state}), 4);
    step();
    if (pre_busy > 0) begin tx_busy = 1'b1; l_cnt = pre_busy; end
    mult_done = 1'b1; step(); mult_done = 1'b0;
    chk("after_done", int'({state, mult_enable}), 5 << 1);
    got = 0; k = 0;
    while (state != 3'd0 && k < 5000) begin
      if ($urandom_range(0, 5) == 0) begin
        rx_data = 8'($urandom_range(0, 255)); rx_valid = 1'b1;
      end
      step(); k++;
      if (rx_valid) begin
        rx_valid = 1'b0;
        chk("send_ignore_rx", int'({wr_en_a, wr_en_b}), 0);
      end
      if (tx_start) begin
        chk("tx_idx", int'(res_idx), got);
        chk("tx_data", int'(tx_data), (got < tot) ? cmod[got] : -1);
        got++;
        if (abort_at > 0 && got == abort_at) begin
          #1 rst = 1'b0;
          #1 chk_zero("reset_mid_send");
          tx_busy = 1'b0; d_cnt = 0; l_cnt = 0;
          step(); rst = 1'b1; step();
          chk("after_abort_state", int'(state), 0);
          return;
        end
      end
    end
    chk("send_timeout", int'(k < 5000), 1);
    chk("tx_count", got, tot);
    chk("end_state", int'({state, res_idx}), 0);
  endtask

  task automatic session(input int n, input bit fixed, input bit gaps, input int pre_busy,
                         input int abort_at);
    send(SYNC);
    chk("sync_state", int'(state), 1);
    send(8'(n));
    chk("size_accept", int'({state, matrix_size}), (2 << 4) | n);
    body(n, fixed, gaps, pre_busy, abort_at);
  endtask

  initial begin
    for (int i = 0; i < 100; i++) cmod[i] = 0;
    #12 chk_zero("reset");
    rst = 1'b1;
    step();

    // Size phase: IDLE discards non-sync, range check on the whole byte,
    // size_err is a single-cycle pulse.
    tbl[0] = '{1'b1, 8'h12, 0, 0, 0};
    tbl[1] = '{1'b1, 8'h00, 0, 0, 0};
    tbl[2] = '{1'b1, 8'hA5, 1, 0, 0};
    tbl[3] = '{1'b1, 8'h00, 1, 1, 0};
    tbl[4] = '{1'b0, 8'h00, 1, 0, 0};
    tbl[5] = '{1'b1, 8'h0B, 1, 1, 0};
    tbl[6] = '{1'b1, 8'h13, 1, 1, 0};
    tbl[7] = '{1'b1, 8'hA5, 1, 1, 0};
    tbl[8] = '{1'b1, 8'h03, 2, 0, 3};
    for (int i = 0; i < 9; i++) begin
      rx_data = tbl[i].b; rx_valid = tbl[i].v; step(); rx_valid = 1'b0;
      chk($sformatf("size_vec%0d", i), int'({state, size_err, matrix_size}),
          (tbl[i].st << 5) | (tbl[i].serr << 4) | tbl[i].msz);
    end
    busy_dly = 1; busy_len = 20;
    body(3, 1'b0, 1'b0, 0, 0);

    // 2x2 reference session: C = 19,22,43,50.
    session(2, 1'b1, 1'b0, 0, 0);

    // tx_busy already high when SEND_START is entered; zero-latency busy.
    busy_dly = 0; busy_len = 3;
    session(2, 1'b1, 1'b1, 15, 0);

    // Largest size: addresses and result indices run to 99.
    busy_dly = 1; busy_len = 2;
    session(MAX_SIZE, 1'b0, 1'b0, 0, 0);

    // Reset after the second tx_start, then a fresh session.
    busy_dly = 1; busy_len = 20;
    session(2, 1'b1, 1'b0, 0, 2);
    session(2, 1'b1, 1'b0, 0, 0);

    // Random sizes, gaps and busy timing.
    for (int r = 0; r < 6; r++) begin
      busy_dly = int'($urandom_range(0, 2));
      busy_len = int'($urandom_range(1, 8));
      session(int'($urandom_range(1, MAX_SIZE)), 1'b0, 1'b1,
              ($urandom_range(0, 1) == 1) ? 5 : 0, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
